// File: rtl/counter_pkg.sv
// Shared types and constants for the loadable saturating down-counter.
// Latency: n/a (package); backpressure: n/a.
package counter_pkg;

    localparam int WIDTH     = 5;
    localparam int COUNT_MAX = (1 << WIDTH) - 1;

    typedef logic [WIDTH-1:0] count_t;

    // IDLE must stay at 0: the state flop clears to all-zeros on reset.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic count_t sat_dec(input count_t v);
        return (v == '0) ? '0 : v - count_t'(1);
    endfunction

endpackage

// File: rtl/dff.sv
// Generic register cell with asynchronous active-low clear to zero.
// Latency: one clock; backpressure: none.
module dff #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_clrn,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            o_q <= '0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/down_counter_5_ctrl.sv
// FSM state register plus next-state/next-count logic and status decode.
// Latency: next values registered on the following edge; backpressure: enable=0 stalls RUN.
module down_counter_5_ctrl
    import counter_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_load,
    input  count_t i_load_value,
    input  logic   i_enable,
    input  logic   i_auto_reload,
    input  count_t i_count,
    input  count_t i_reload,
    output count_t o_count_nxt,
    output count_t o_reload_nxt,
    output logic   o_busy,
    output logic   o_done
);

    logic [1:0] r_state;
    state_t     w_state;
    state_t     w_state_nxt;

    dff #(.W(2)) u_state (
        .i_clk  (i_clk),
        .i_clrn (i_rst_n),
        .i_d    (w_state_nxt),
        .o_q    (r_state)
    );

    assign w_state = state_t'(r_state);

    always_comb begin
        w_state_nxt  = w_state;
        o_count_nxt  = i_count;
        o_reload_nxt = i_reload;

        if (i_load) begin
            // A load always wins and silently abandons any run in progress.
            o_count_nxt  = i_load_value;
            o_reload_nxt = i_load_value;
            w_state_nxt  = (i_load_value != '0) ? RUN : DONE;
        end else begin
            unique case (w_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                RUN: begin
                    if (i_enable) begin
                        o_count_nxt = sat_dec(i_count);
                        if (i_count <= count_t'(1)) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (i_auto_reload && (i_reload != '0)) begin
                        o_count_nxt = i_reload;
                        w_state_nxt = RUN;
                    end else begin
                        o_count_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    o_count_nxt = '0;
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign o_busy = (w_state == RUN);
    assign o_done = (w_state == DONE);

endmodule

// File: rtl/down_counter_5.sv
// Loadable 5-bit saturating down-counter used as an iterative-op step timer.
// Latency: count/busy/done update one edge after inputs; backpressure: enable=0 holds count.
module down_counter_5
    import counter_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_enable,
    input  logic             i_auto_reload,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_zero
);

    count_t r_count;
    count_t r_reload;
    count_t w_count_nxt;
    count_t w_reload_nxt;

    dff #(.W(WIDTH)) u_count (
        .i_clk  (i_clk),
        .i_clrn (i_rst_n),
        .i_d    (w_count_nxt),
        .o_q    (r_count)
    );

    dff #(.W(WIDTH)) u_reload (
        .i_clk  (i_clk),
        .i_clrn (i_rst_n),
        .i_d    (w_reload_nxt),
        .o_q    (r_reload)
    );

    down_counter_5_ctrl u_ctrl (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_load        (i_load),
        .i_load_value  (i_load_value),
        .i_enable      (i_enable),
        .i_auto_reload (i_auto_reload),
        .i_count       (r_count),
        .i_reload      (r_reload),
        .o_count_nxt   (w_count_nxt),
        .o_reload_nxt  (w_reload_nxt),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
